// File: rtl/banked_dual_port_ram.sv
// banked_dual_port_ram
// Two-port banked synchronous RAM with a request/grant handshake per port.
// Different-bank accesses proceed in parallel; same-bank accesses are
// serialised by a one-bit round-robin priority register.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_x, we_x            request and write enable (x = a, b)
//   addr_x, wdata_x        word address and write data
//   gnt_x                  combinational grant for the current cycle
//   rvalid_x, rdata_x      read data valid / read data, one cycle after a read grant
module banked_dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned BANK_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int unsigned NUM_BANKS  = 1 << BANK_BITS;
    localparam int unsigned LOCAL_W    = ADDR_WIDTH - BANK_BITS;
    localparam int unsigned BANK_DEPTH = 1 << LOCAL_W;

    // Address decode
    logic [BANK_BITS-1:0] bank_a_c;
    logic [BANK_BITS-1:0] bank_b_c;
    logic [LOCAL_W-1:0]   local_a_c;
    logic [LOCAL_W-1:0]   local_b_c;

    assign bank_a_c  = addr_a[ADDR_WIDTH-1 -: BANK_BITS];
    assign bank_b_c  = addr_b[ADDR_WIDTH-1 -: BANK_BITS];
    assign local_a_c = addr_a[LOCAL_W-1:0];
    assign local_b_c = addr_b[LOCAL_W-1:0];

    // Arbitration: pri_q names the port that wins the next same-bank conflict
    logic pri_q;
    logic conflict_c;
    logic gnt_a_c;
    logic gnt_b_c;

    assign conflict_c = req_a && req_b && (bank_a_c == bank_b_c);
    assign gnt_a_c    = !rst && req_a && (!conflict_c || !pri_q);
    assign gnt_b_c    = !rst && req_b && (!conflict_c ||  pri_q);

    assign gnt_a = gnt_a_c;
    assign gnt_b = gnt_b_c;

    // Registered output of every bank's read port
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    // One single-port array per bank; at most one port reaches a bank per cycle
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  sel_a_c;
        logic                  sel_b_c;

        assign sel_a_c = gnt_a_c && (bank_a_c == BANK_BITS'(b));
        assign sel_b_c = gnt_b_c && (bank_b_c == BANK_BITS'(b));

        // Contents and read register are intentionally not reset
        always_ff @(posedge clk) begin
            if (sel_a_c) begin
                if (we_a) mem_q[local_a_c] <= wdata_a;
                else      rd_q             <= mem_q[local_a_c];
            end else if (sel_b_c) begin
                if (we_b) mem_q[local_b_c] <= wdata_b;
                else      rd_q             <= mem_q[local_b_c];
            end
        end

        assign bank_rdata[b] = rd_q;
    end

    // Per-port read tracking: which bank holds this port's data, plus a hold
    // register so rdata keeps its value after the bank is reused by the other port
    logic                  rvalid_a_q;
    logic                  rvalid_b_q;
    logic [BANK_BITS-1:0]  rbank_a_q;
    logic [BANK_BITS-1:0]  rbank_b_q;
    logic [DATA_WIDTH-1:0] hold_a_q;
    logic [DATA_WIDTH-1:0] hold_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q      <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rbank_a_q  <= '0;
            rbank_b_q  <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else begin
            // Hand priority to the loser of a conflict
            if (conflict_c) pri_q <= ~pri_q;

            rvalid_a_q <= gnt_a_c && !we_a;
            rvalid_b_q <= gnt_b_c && !we_b;

            if (gnt_a_c && !we_a) rbank_a_q <= bank_a_c;
            if (gnt_b_c && !we_b) rbank_b_q <= bank_b_c;

            if (rvalid_a_q) hold_a_q <= bank_rdata[rbank_a_q];
            if (rvalid_b_q) hold_b_q <= bank_rdata[rbank_b_q];
        end
    end

    // Fresh data straight from the bank register in the valid cycle, held value otherwise
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rvalid_a_q ? bank_rdata[rbank_a_q] : hold_a_q;
    assign rdata_b  = rvalid_b_q ? bank_rdata[rbank_b_q] : hold_b_q;

endmodule

// File: tb/tb_banked_dual_port_ram.sv
// Self-checking bench for banked_dual_port_ram: a behavioural model (sparse
// word map plus priority bit) checked every cycle, and directed vectors with
// literal expectations.
module tb_banked_dual_port_ram;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 15;
    localparam int unsigned BB  = 2;
    localparam int unsigned LW  = AW - BB;

    logic          clk;
    logic          rst;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;

    banked_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BITS(BB)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [int];
    bit            m_pri     = 1'b0;
    bit            m_started = 1'b0;
    bit            m_rv_a, m_rv_b;
    bit            m_kn_a, m_kn_b;
    logic [DW-1:0] m_rd_a, m_rd_b;

    function automatic void mdl_grants(output bit ga, output bit gb);
        int ba, bb;
        ba = int'(addr_a) >> LW;
        bb = int'(addr_b) >> LW;
        if (rst) begin
            ga = 1'b0; gb = 1'b0;
        end else if (req_a && req_b && ba == bb) begin
            ga = (m_pri == 1'b0);
            gb = !ga;
        end else begin
            ga = req_a; gb = req_b;
        end
    endfunction

    always @(posedge clk) begin
        bit ga, gb;
        mdl_grants(ga, gb);
        if (rst) begin
            m_started = 1'b1;
            m_pri  = 1'b0;
            m_rv_a = 1'b0; m_rv_b = 1'b0;
            m_rd_a = '0;   m_rd_b = '0;
            m_kn_a = 1'b1; m_kn_b = 1'b1;
        end else begin
            if (req_a && req_b && ((int'(addr_a) >> LW) == (int'(addr_b) >> LW)))
                m_pri = !m_pri;
            m_rv_a = ga && !we_a;
            m_rv_b = gb && !we_b;
            if (m_rv_a) begin
                m_kn_a = m_mem.exists(int'(addr_a));
                if (m_kn_a) m_rd_a = m_mem[int'(addr_a)];
            end
            if (m_rv_b) begin
                m_kn_b = m_mem.exists(int'(addr_b));
                if (m_kn_b) m_rd_b = m_mem[int'(addr_b)];
            end
            if (ga && we_a) m_mem[int'(addr_a)] = wdata_a;
            if (gb && we_b) m_mem[int'(addr_b)] = wdata_b;
        end
    end

    // Compare process: every cycle once reset has been seen
    always @(negedge clk) begin
        bit eg_a, eg_b;
        if (m_started) begin
            mdl_grants(eg_a, eg_b);
            chk("mdl_gnt_a", 32'(gnt_a), 32'(eg_a));
            chk("mdl_gnt_b", 32'(gnt_b), 32'(eg_b));
            chk("mdl_rvalid_a", 32'(rvalid_a), 32'(m_rv_a));
            chk("mdl_rvalid_b", 32'(rvalid_b), 32'(m_rv_b));
            if (m_kn_a) chk("mdl_rdata_a", 32'(rdata_a), 32'(m_rd_a));
            if (m_kn_b) chk("mdl_rdata_b", 32'(rdata_b), 32'(m_rd_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        req_a = r; we_a = w; addr_a = ad; wdata_a = wd;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        req_b = r; we_b = w; addr_b = ad; wdata_b = wd;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        // Reset with both ports trying to write
        set_a(1'b1, 1'b1, 15'h1000, 16'hDEAD);
        set_b(1'b1, 1'b1, 15'h5000, 16'hDEAD);
        @(negedge clk);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_rdata_b", 32'(rdata_b), 32'd0);
        tick();
        tick();

        // Seed two words, then reset again while writing junk over them
        rst = 1'b0;
        set_a(1'b1, 1'b1, 15'h1000, 16'h1111);
        set_b(1'b1, 1'b1, 15'h5000, 16'h5555);
        @(negedge clk);
        chk("seed_gnt_a", 32'(gnt_a), 32'd1);
        chk("seed_gnt_b", 32'(gnt_b), 32'd1);
        tick();
        rst = 1'b1;
        set_a(1'b1, 1'b1, 15'h1000, 16'hDEAD);
        set_b(1'b1, 1'b1, 15'h5000, 16'hDEAD);
        tick();
        tick();
        rst = 1'b0;
        set_a(1'b1, 1'b0, 15'h1000, '0);
        set_b(1'b1, 1'b0, 15'h5000, '0);
        tick();
        idle();
        @(negedge clk);
        chk("rst_nowrite_a", 32'(rdata_a), 32'h1111);
        chk("rst_nowrite_b", 32'(rdata_b), 32'h5555);

        // Single-port round trip
        set_a(1'b1, 1'b1, 15'h1FFC, 16'h1234);
        @(negedge clk);
        chk("rt_wr_gnt_a", 32'(gnt_a), 32'd1);
        tick();
        set_a(1'b1, 1'b0, 15'h1FFC, '0);
        @(negedge clk);
        chk("rt_rd_gnt_a", 32'(gnt_a), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("rt_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("rt_rdata_a", 32'(rdata_a), 32'h1234);
        tick();
        @(negedge clk);
        chk("rt_rvalid_a_off", 32'(rvalid_a), 32'd0);
        chk("rt_rdata_a_hold", 32'(rdata_a), 32'h1234);

        // Parallel banks, including the top address
        set_a(1'b1, 1'b1, 15'h3FFF, 16'hBEEF);
        set_b(1'b1, 1'b1, 15'h7FFF, 16'hCAFE);
        @(negedge clk);
        chk("par_gnt_a", 32'(gnt_a), 32'd1);
        chk("par_gnt_b", 32'(gnt_b), 32'd1);
        tick();
        set_a(1'b1, 1'b0, 15'h7FFF, '0);
        set_b(1'b1, 1'b0, 15'h3FFF, '0);
        tick();
        idle();
        @(negedge clk);
        chk("par_rdata_a", 32'(rdata_a), 32'hCAFE);
        chk("par_rdata_b", 32'(rdata_b), 32'hBEEF);
        chk("par_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("par_rvalid_b", 32'(rvalid_b), 32'd1);

        // Conflict fairness in bank 1
        set_a(1'b1, 1'b1, 15'h2000, 16'hA000);
        tick();
        set_a(1'b1, 1'b1, 15'h2001, 16'hB001);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_a(1'b1, 1'b0, 15'h2000, '0);
        set_b(1'b1, 1'b0, 15'h2001, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fair_gnt_a", 32'(gnt_a), 32'((i % 2) == 0));
            chk("fair_gnt_b", 32'(gnt_b), 32'((i % 2) == 1));
            chk("fair_addr_a_held", 32'(addr_a), 32'h2000);
            if (i > 0) begin
                chk("fair_rvalid_a", 32'(rvalid_a), 32'(((i - 1) % 2) == 0));
                chk("fair_rvalid_b", 32'(rvalid_b), 32'(((i - 1) % 2) == 1));
                if ((i - 1) % 2 == 0) chk("fair_rdata_a", 32'(rdata_a), 32'hA000);
                else                  chk("fair_rdata_b", 32'(rdata_b), 32'hB001);
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("fair_last_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("fair_last_rdata_b", 32'(rdata_b), 32'hB001);

        // Cross-port write then read
        set_a(1'b1, 1'b1, 15'h6003, 16'h5A5A);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b1, 1'b0, 15'h6003, '0);
        tick();
        idle();
        @(negedge clk);
        chk("xp_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("xp_rdata_b", 32'(rdata_b), 32'h5A5A);

        // Reset in the middle of a read stream
        for (int i = 0; i < 4; i++) begin
            set_b(1'b1, 1'b1, AW'(i), DW'(16'h0100 + i));
            tick();
        end
        idle();
        set_a(1'b1, 1'b0, 15'h0000, '0);
        @(negedge clk);
        chk("ms_gnt0", 32'(gnt_a), 32'd1);
        tick();
        set_a(1'b1, 1'b0, 15'h0001, '0);
        @(negedge clk);
        chk("ms_rdata0", 32'(rdata_a), 32'h0100);
        tick();
        rst = 1'b1;
        set_a(1'b1, 1'b0, 15'h0002, '0);
        @(negedge clk);
        chk("ms_rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("ms_rvalid_pre", 32'(rvalid_a), 32'd1);
        chk("ms_rdata1", 32'(rdata_a), 32'h0101);
        tick();
        @(negedge clk);
        chk("ms_rvalid_drop", 32'(rvalid_a), 32'd0);
        chk("ms_rdata_clr", 32'(rdata_a), 32'd0);
        tick();
        rst = 1'b0;
        set_b(1'b1, 1'b0, 15'h0003, '0);
        @(negedge clk);
        chk("ms_post_gnt_a", 32'(gnt_a), 32'd1);
        chk("ms_post_gnt_b", 32'(gnt_b), 32'd0);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("ms_post2_gnt_b", 32'(gnt_b), 32'd1);
        chk("ms_post_rdata_a", 32'(rdata_a), 32'h0102);
        tick();
        idle();
        @(negedge clk);
        chk("ms_post_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("ms_post_rdata_b", 32'(rdata_b), 32'h0103);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
